// File: rtl/miter_drv_pkg.sv
// Shared definitions for the miter pattern driver: FSM states and the
// x^21+x^19+1 Fibonacci LFSR successor.
package miter_drv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_APPLY = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam int LFSR_W = 21;
    localparam int TAP_HI = 20;
    localparam int TAP_LO = 18;

    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] v);
        return {v[LFSR_W-2:0], v[TAP_HI] ^ v[TAP_LO]};
    endfunction

endpackage

// File: rtl/lfsr21.sv
// Loadable 21-bit Fibonacci LFSR; load takes priority over step.
module lfsr21
    import miter_drv_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic [LFSR_W-1:0] i_load_val,
    input  logic              i_step,
    output logic [LFSR_W-1:0] o_q
);

    logic [LFSR_W-1:0] r_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= i_load_val;
        end else if (i_step) begin
            r_q <= lfsr_next(r_q);
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/miter_pattern_driver.sv
// Drives LFSR vectors into a combinational miter, holds each for SETTLE+1
// cycles, samples the miter output on the last cycle and logs mismatches.
module miter_pattern_driver
    import miter_drv_pkg::*;
#(
    parameter int VEC_W  = 21,
    parameter int CNT_W  = 16,
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [VEC_W-1:0] seed,
    input  logic [CNT_W-1:0] num_vectors,
    output logic [VEC_W-1:0] vec_out,
    input  logic             miter_in,
    output logic             busy,
    output logic             done,
    output logic             fail,
    output logic [CNT_W-1:0] fail_count,
    output logic [VEC_W-1:0] first_fail_vec,
    output logic [CNT_W-1:0] first_fail_idx
);

    localparam int HOLD_W = 4;
    localparam logic [HOLD_W-1:0] SETTLE_H = HOLD_W'(SETTLE);
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

    state_t           r_state;
    logic [CNT_W-1:0] r_idx;
    logic [CNT_W-1:0] r_num;
    logic [HOLD_W-1:0] r_hold;
    logic [CNT_W-1:0] r_fail_count;
    logic [VEC_W-1:0] r_first_vec;
    logic [CNT_W-1:0] r_first_idx;
    logic             r_busy;
    logic             r_done;

    logic             w_accept;
    logic             w_sample;
    logic             w_last;
    logic             w_load;
    logic             w_step;
    logic [VEC_W-1:0] w_seed_fix;
    logic [VEC_W-1:0] w_vec;

    assign w_accept   = (r_state == ST_IDLE) && start;
    assign w_sample   = (r_state == ST_APPLY) && (r_hold == SETTLE_H);
    assign w_last     = (r_idx == r_num - CNT_W'(1));
    assign w_load     = w_accept && (num_vectors != '0);
    assign w_step     = w_sample && !w_last;
    // An all-zero seed would lock the LFSR at zero.
    assign w_seed_fix = (seed == '0) ? VEC_W'(1) : seed;

    lfsr21 u_lfsr (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_load_val (w_seed_fix),
        .i_step     (w_step),
        .o_q        (w_vec)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_idx        <= '0;
            r_num        <= '0;
            r_hold       <= '0;
            r_fail_count <= '0;
            r_first_vec  <= '0;
            r_first_idx  <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_fail_count <= '0;
                        if (num_vectors != '0) begin
                            r_num       <= num_vectors;
                            r_idx       <= '0;
                            r_hold      <= '0;
                            r_first_vec <= '0;
                            r_first_idx <= '0;
                            r_busy      <= 1'b1;
                            r_state     <= ST_APPLY;
                        end else begin
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end
                    end
                end
                ST_APPLY: begin
                    r_hold <= r_hold + HOLD_W'(1);
                    if (w_sample) begin
                        if (miter_in) begin
                            if (r_fail_count != CNT_MAX) begin
                                r_fail_count <= r_fail_count + CNT_W'(1);
                            end
                            if (r_fail_count == '0) begin
                                r_first_vec <= w_vec;
                                r_first_idx <= r_idx;
                            end
                        end
                        if (w_last) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end else begin
                            r_idx  <= r_idx + CNT_W'(1);
                            r_hold <= '0;
                        end
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign vec_out        = w_vec;
    assign busy           = r_busy;
    assign done           = r_done;
    assign fail           = (r_fail_count != '0);
    assign fail_count     = r_fail_count;
    assign first_fail_vec = r_first_vec;
    assign first_fail_idx = r_first_idx;

endmodule

// File: tb/tb_miter_pattern_driver.sv
// Bench for miter_pattern_driver: directed and random runs against a
// vector-list reference model, plus a SETTLE=0 instance for long runs.
module tb_miter_pattern_driver;

    localparam int VW = 21;
    localparam int CW = 16;
    localparam int S1 = 1;

    logic          clk = 1'b0;
    logic          rst;
    always #5 clk = ~clk;

    // Instance 1: default parameters, miter emulated by the bench.
    logic          start;
    logic [VW-1:0] seed;
    logic [CW-1:0] num_vectors;
    logic [VW-1:0] vec_out;
    logic          miter_in;
    logic          busy, done, fail;
    logic [CW-1:0] fail_count, first_fail_idx;
    logic [VW-1:0] first_fail_vec;

    // Instance 2: SETTLE=0, miter tied high.
    logic          start2;
    logic [VW-1:0] seed2;
    logic [CW-1:0] num2;
    logic [VW-1:0] vec_out2;
    logic          miter2;
    logic          busy2, done2, fail2;
    logic [CW-1:0] fail_count2, first_fail_idx2;
    logic [VW-1:0] first_fail_vec2;

    int n_assert = 0;
    int n_fail   = 0;

    int            mode;
    logic [VW-1:0] target;
    logic [VW-1:0] mask;
    logic          glitch_en;
    logic [VW-1:0] prev_vec;

    miter_pattern_driver #(.VEC_W(VW), .CNT_W(CW), .SETTLE(S1)) dut (
        .clk(clk), .rst(rst), .start(start), .seed(seed), .num_vectors(num_vectors),
        .vec_out(vec_out), .miter_in(miter_in), .busy(busy), .done(done), .fail(fail),
        .fail_count(fail_count), .first_fail_vec(first_fail_vec), .first_fail_idx(first_fail_idx)
    );

    miter_pattern_driver #(.VEC_W(VW), .CNT_W(CW), .SETTLE(0)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .seed(seed2), .num_vectors(num2),
        .vec_out(vec_out2), .miter_in(miter2), .busy(busy2), .done(done2), .fail(fail2),
        .fail_count(fail_count2), .first_fail_vec(first_fail_vec2), .first_fail_idx(first_fail_idx2)
    );

    // Reference miter: a fixed function of the vector under test.
    function automatic logic pred(input int md, input logic [VW-1:0] v,
                                  input logic [VW-1:0] tg, input logic [VW-1:0] mk);
        case (md)
            0:       return 1'b0;
            1:       return 1'b1;
            2:       return (v == tg);
            default: return ^(v & mk);
        endcase
    endfunction

    function automatic logic [VW-1:0] succ(input logic [VW-1:0] v);
        logic fb;
        fb = v[20] ^ v[18];
        return (v << 1) | VW'(fb);
    endfunction

    // Spurious mismatches right after each vector change must be ignored.
    always @(posedge clk) prev_vec <= vec_out;
    assign miter_in = pred(mode, vec_out, target, mask) | (glitch_en & (vec_out != prev_vec));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run1(input logic [VW-1:0] s, input int n, input int restart_at, input string tag);
        logic [VW-1:0] v, last_v, first_v;
        logic [VW-1:0] exp_q[$];
        logic [VW-1:0] got_q[$];
        int exp_fails, exp_fidx, mism, budget;
        logic [VW-1:0] exp_fvec;
        logic seen;

        first_v   = (s == '0) ? VW'(1) : s;
        v         = first_v;
        last_v    = v;
        exp_fails = 0;
        exp_fidx  = 0;
        exp_fvec  = '0;
        for (int i = 0; i < n; i++) begin
            if (pred(mode, v, target, mask)) begin
                if (exp_fails == 0) begin
                    exp_fidx = i;
                    exp_fvec = v;
                end
                if (exp_fails < 65535) exp_fails++;
            end
            for (int k = 0; k <= S1; k++) exp_q.push_back(v);
            last_v = v;
            v = succ(v);
        end

        @(negedge clk);
        seed        = s;
        num_vectors = CW'(n);
        start       = 1'b1;
        seen        = 1'b0;
        budget      = n * (S1 + 1) + 20;
        for (int c = 0; c < budget && !seen; c++) begin
            @(negedge clk);
            if (busy) got_q.push_back(vec_out);
            if (done) seen = 1'b1;
            if (c == 0) start = 1'b0;
            if (c == restart_at) begin
                start       = 1'b1;
                seed        = VW'($urandom);
                num_vectors = CW'($urandom_range(1, 5));
            end
            if (c == restart_at + 1) start = 1'b0;
        end
        start = 1'b0;
        check({tag, " done seen"}, 32'(seen), 32'd1);
        check({tag, " busy cycles"}, 32'(got_q.size()), 32'(exp_q.size()));
        mism = 0;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            if (got_q[i] !== exp_q[i]) mism++;
        check({tag, " vector sequence errors"}, 32'(mism), 32'd0);
        if (got_q.size() > 0) check({tag, " first vec"}, 32'(got_q[0]), 32'(first_v));
        check({tag, " fail_count"}, 32'(fail_count), 32'(exp_fails));
        check({tag, " fail"}, 32'(fail), 32'(exp_fails != 0));
        if (exp_fails != 0) begin
            check({tag, " first_fail_vec"}, 32'(first_fail_vec), 32'(exp_fvec));
            check({tag, " first_fail_idx"}, 32'(first_fail_idx), 32'(exp_fidx));
        end
        check({tag, " final vec_out"}, 32'(vec_out), 32'(last_v));
        @(negedge clk);
        check({tag, " done single pulse"}, 32'(done), 32'd0);
        check({tag, " busy after"}, 32'(busy), 32'd0);
    endtask

    task automatic run2(input int n, input string tag);
        logic [VW-1:0] s;
        int busy_cnt;
        logic seen;
        s = VW'($urandom);
        @(negedge clk);
        seed2  = s;
        num2   = CW'(n);
        start2 = 1'b1;
        seen   = 1'b0;
        busy_cnt = 0;
        for (int c = 0; c < n + 20 && !seen; c++) begin
            @(negedge clk);
            if (busy2) busy_cnt++;
            if (done2) seen = 1'b1;
            if (c == 0) start2 = 1'b0;
        end
        start2 = 1'b0;
        check({tag, " done seen"}, 32'(seen), 32'd1);
        check({tag, " busy cycles"}, 32'(busy_cnt), 32'(n));
        check({tag, " fail_count"}, 32'(fail_count2), 32'(n));
        check({tag, " fail"}, 32'(fail2), 32'd1);
        check({tag, " first_fail_idx"}, 32'(first_fail_idx2), 32'd0);
        check({tag, " first_fail_vec"}, 32'(first_fail_vec2), 32'((s == '0) ? VW'(1) : s));
    endtask

    initial begin
        logic [VW-1:0] vbefore;
        logic          done_during_rst;

        rst = 1'b1; start = 1'b0; seed = '0; num_vectors = '0;
        start2 = 1'b0; seed2 = '0; num2 = '0; miter2 = 1'b1;
        mode = 0; target = '0; mask = '0; glitch_en = 1'b0;
        repeat (2) @(negedge clk);
        check("reset vec_out", 32'(vec_out), 32'd0);
        check("reset busy/done/fail", {29'd0, busy, done, fail}, 32'd0);
        check("reset fail_count", 32'(fail_count), 32'd0);
        check("reset first_fail_vec", 32'(first_fail_vec), 32'd0);
        check("reset first_fail_idx", 32'(first_fail_idx), 32'd0);
        check("reset dut2 busy/done", {30'd0, busy2, done2}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Clean miter, glitches on settle cycles only.
        mode = 0; glitch_en = 1'b1;
        run1(21'd1, 4, -10, "clean4");

        // Single mismatch at vector 0x000002.
        mode = 2; target = 21'h000002;
        run1(21'd1, 6, -10, "target2");
        check("target2 explicit count", 32'(fail_count), 32'd1);
        check("target2 explicit vec", 32'(first_fail_vec), 32'h2);
        check("target2 explicit idx", 32'(first_fail_idx), 32'd1);

        // Zero vectors: done one cycle after start, vec_out untouched.
        vbefore = vec_out;
        @(negedge clk);
        num_vectors = '0; seed = 21'h1234; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("zero done", 32'(done), 32'd1);
        check("zero busy", 32'(busy), 32'd0);
        check("zero vec_out", 32'(vec_out), 32'(vbefore));
        check("zero fail_count", 32'(fail_count), 32'd0);
        @(negedge clk);
        check("zero done drop", 32'(done), 32'd0);
        check("zero busy after", 32'(busy), 32'd0);

        // Seed 0 maps to 1; a start mid-run must be ignored.
        mode = 3; mask = VW'($urandom);
        run1(21'd0, 8, 3, "seed0_restart");

        // Reset partway through a 10-vector run.
        @(negedge clk);
        seed = VW'($urandom); num_vectors = CW'(10); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("midrun busy", 32'(busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("midrun rst vec_out", 32'(vec_out), 32'd0);
        check("midrun rst flags", {29'd0, busy, done, fail}, 32'd0);
        check("midrun rst counts", {fail_count, first_fail_idx}, 32'd0);
        check("midrun rst first vec", 32'(first_fail_vec), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        done_during_rst = 1'b0;
        repeat (25) begin
            @(negedge clk);
            if (done || busy) done_during_rst = 1'b1;
        end
        check("post-abort no done/busy", 32'(done_during_rst), 32'd0);
        run1(VW'($urandom), 10, -10, "after_abort");

        // Random runs against the reference model.
        for (int r = 0; r < 6; r++) begin
            mode = 3; mask = VW'($urandom); glitch_en = 1'b1;
            run1(VW'($urandom), $urandom_range(1, 40), -10, $sformatf("rand%0d", r));
        end

        // Full-length run on the SETTLE=0 instance, then a short rerun.
        run2(65535, "full16");
        run2(3, "rerun3");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/miter_pattern_driver.md
MITER_PATTERN_DRIVER -- requirements
Module: miter_pattern_driver

Interface
REQ-001 SHALL take parameter VEC_W, default 21, the miter input vector width.
REQ-002 SHALL take parameter CNT_W, default 16, the width of the vector and fail counters.
REQ-003 SHALL take parameter SETTLE, default 1, the settle cycles per vector before sampling, legal range 0..15.
REQ-004 SHALL use one clock; reset is asynchronous and active-high.
REQ-005 SHALL have port clk, input, 1, the sole clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port start, input, 1, a run request, honoured only in IDLE.
REQ-008 SHALL have port seed, input, VEC_W, the LFSR seed, sampled with start.
REQ-009 SHALL have port num_vectors, input, CNT_W, the vector count, sampled with start.
REQ-010 SHALL have port vec_out, output, VEC_W, registered stimulus driving the combinational miter inputs.
REQ-011 SHALL have port miter_in, input, 1, the miter xor output (1 = mismatch).
REQ-012 SHALL have port busy, output, 1, high in APPLY.
REQ-013 SHALL have port done, output, 1, a one-cycle pulse at run end.
REQ-014 SHALL have port fail, output, 1, high when fail_count is nonzero.
REQ-015 SHALL have port fail_count, output, CNT_W, the number of mismatching vectors, saturating.
REQ-016 SHALL have port first_fail_vec, output, VEC_W, vec_out at the first mismatch.
REQ-017 SHALL have port first_fail_idx, output, CNT_W, the zero-based vector index of the first mismatch.

Function
REQ-018 SHALL implement the FSM states IDLE, APPLY and DONE.
REQ-019 SHALL, in IDLE with start=1 and num_vectors>0, load vec_out from seed (seed==0 loads 1), clear the idx, hold, fail_count and first-fail registers, and enter APPLY.
REQ-020 SHALL, in IDLE with start=1 and num_vectors==0, clear fail_count, leave vec_out unchanged, and enter DONE.
REQ-021 SHALL, in APPLY, increment hold each cycle and sample miter_in on the cycle where hold==SETTLE.
REQ-022 SHALL, when the sample is 1, increment fail_count (held at all-ones once saturated) and, if fail_count was 0, capture first_fail_vec=vec_out and first_fail_idx=idx.
REQ-023 SHALL, at the sample cycle with idx==num_vectors-1, enter DONE; otherwise vec_out becomes the LFSR successor, idx increments and hold clears.
REQ-024 SHALL hold each vector exactly SETTLE+1 cycles, so a run of N vectors spends N*(SETTLE+1) cycles in APPLY.
REQ-025 SHALL use the LFSR successor {v[VEC_W-2:0], v[20]^v[18]}, i.e. x^21+x^19+1, which is maximal length.
REQ-026 SHALL, in DONE, drive done=1 for exactly one cycle, drive busy=0, and return to IDLE.
REQ-027 SHALL ignore start in APPLY and DONE.
REQ-028 SHALL hold fail_count, first_fail_* and vec_out stable in IDLE until the next accepted start.
REQ-029 SHALL not sample miter_in outside the sample cycle; mismatches during settle cycles are ignored.

Reset
REQ-030 SHALL, on rst, set state=IDLE and clear vec_out, fail_count, first_fail_vec, first_fail_idx, idx and hold to 0, with busy, done and fail at 0.
REQ-031 SHALL abort a run when rst asserts mid-run, with no done pulse and all results cleared.

Structure
REQ-032 SHALL place the state enum, the LFSR tap constants and the lfsr_next function in the shared package miter_drv_pkg.
REQ-033 SHALL instantiate exactly one sub-module, lfsr21, which provides the load/step 21-bit Fibonacci LFSR.

Verification
REQ-034 SHALL cover: miter_in tied 0, seed=1, num_vectors=4, SETTLE=1 -> busy for 8 cycles, done pulses once, fail_count=0, fail=0.
REQ-035 SHALL cover: seed=1, miter_in=1 only while vec_out==0x000002 -> fail_count=1, first_fail_vec=0x000002, first_fail_idx=1.
REQ-036 SHALL cover: miter_in tied 1, num_vectors=0xFFFF, CNT_W=16 -> fail_count=0xFFFF and first_fail_idx=0; then rerun with num_vectors=3 -> fail_count=3.
REQ-037 SHALL cover: num_vectors=0 -> done is asserted 1 cycle after start, busy is never asserted, and vec_out is unchanged.
REQ-038 SHALL cover: seed=0 -> first vec_out=0x000001; start pulsed during APPLY -> no restart, idx sequence continues.
REQ-039 SHALL cover: rst asserted at cycle 3 of a 10-vector run -> IDLE, all outputs 0, no done pulse; the next start runs normally.
